// File: rtl/writeback.sv
// writeback: Y86 W pipeline register, register-file write-port driver, halt detection and retire counter.
module writeback #(
  parameter int WORD_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        M_stat,
  input  logic [3:0]        M_icode,
  input  logic [3:0]        M_dstE,
  input  logic [3:0]        M_dstM,
  input  logic [WORD_W-1:0] M_valE,
  input  logic [WORD_W-1:0] m_valM,
  input  logic              W_stall,
  input  logic              W_bubble,
  output logic [3:0]        dstE,
  output logic [3:0]        dstM,
  output logic [WORD_W-1:0] valE,
  output logic [WORD_W-1:0] valM,
  output logic [3:0]        W_icode,
  output logic [3:0]        Stat,
  output logic              halted,
  output logic [31:0]       retired
);
  localparam logic [3:0] AOK = 4'd1, NOP = 4'd1, RNONE = 4'hF;
  typedef enum logic {RUN, STOP} state_t;
  state_t            state_q;
  logic              valid_q, halted_q;
  logic [3:0]        stat_q, icode_q, dste_q, dstm_q, fin_q;
  logic [WORD_W-1:0] vale_q, valm_q;
  logic [31:0]       retired_q, retired_d;
  logic              wr_en, exc;
  always_comb begin
    exc       = valid_q && stat_q != AOK;
    wr_en     = valid_q && stat_q == AOK && state_q == RUN;
    retired_d = (wr_en && !W_stall) ? retired_q + 32'd1 : retired_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RUN;
      halted_q  <= 1'b0;
      fin_q     <= AOK;
      retired_q <= '0;
      valid_q   <= 1'b0;
      stat_q    <= AOK;
      icode_q   <= NOP;
      dste_q    <= RNONE;
      dstm_q    <= RNONE;
      vale_q    <= '0;
      valm_q    <= '0;
    end else if (state_q == RUN) begin
      retired_q <= retired_d;
      if (exc) begin
        state_q  <= STOP;
        halted_q <= 1'b1;
        fin_q    <= stat_q;
      end
      if (!W_stall) begin
        valid_q <= !W_bubble;
        stat_q  <= W_bubble ? AOK : M_stat;
        icode_q <= W_bubble ? NOP : M_icode;
        dste_q  <= W_bubble ? RNONE : M_dstE;
        dstm_q  <= W_bubble ? RNONE : M_dstM;
        vale_q  <= W_bubble ? '0 : M_valE;
        valm_q  <= W_bubble ? '0 : m_valM;
      end
    end
  end
  // A collision on one register lets the memory result win (popl %esp).
  assign dstM    = wr_en ? dstm_q : RNONE;
  assign dstE    = (wr_en && dste_q != dstm_q) ? dste_q : RNONE;
  assign valE    = vale_q;
  assign valM    = valm_q;
  assign W_icode = icode_q;
  assign Stat    = state_q == STOP ? fin_q : exc ? stat_q : AOK;
  assign halted  = halted_q;
  assign retired = retired_q;
endmodule

// File: tb/tb_writeback.sv
// tb_writeback: directed checks of the writeback stage against hand-computed values.
module tb_writeback;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  M_stat = 4'd1, M_icode = 4'd6, M_dstE = 4'd5, M_dstM = 4'd7;
  logic [31:0] M_valE = 32'hDEAD_BEEF, m_valM = 32'h1234_5678;
  logic        W_stall = 1'b0, W_bubble = 1'b0;
  logic [3:0]  dstE, dstM, W_icode, Stat;
  logic [31:0] valE, valM, retired;
  logic        halted;
  int tests = 0, fails = 0;

  writeback #(.WORD_W(32)) dut (
    .clk(clk), .rst(rst), .M_stat(M_stat), .M_icode(M_icode), .M_dstE(M_dstE),
    .M_dstM(M_dstM), .M_valE(M_valE), .m_valM(m_valM), .W_stall(W_stall),
    .W_bubble(W_bubble), .dstE(dstE), .dstM(dstM), .valE(valE), .valM(valM),
    .W_icode(W_icode), .Stat(Stat), .halted(halted), .retired(retired)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [3:0] st, ic, de, dm, input logic [31:0] ve, vm);
    M_stat = st; M_icode = ic; M_dstE = de; M_dstM = dm; M_valE = ve; m_valM = vm;
  endtask

  initial begin
    tick();
    tick();
    chk("rst_dstE", dstE, 4'hF);
    chk("rst_dstM", dstM, 4'hF);
    chk("rst_valE", valE, 32'h0);
    chk("rst_icode", W_icode, 4'd1);
    chk("rst_stat", Stat, 4'd1);
    chk("rst_halted", halted, 1'b0);
    chk("rst_retired", retired, 32'd0);
    drive(4'd1, 4'd6, 4'd3, 4'hF, 32'hAA, 32'h0);
    rst = 1'b0;
    tick();
    chk("plain_dstE", dstE, 4'd3);
    chk("plain_valE", valE, 32'hAA);
    chk("plain_dstM", dstM, 4'hF);
    chk("plain_icode", W_icode, 4'd6);
    chk("plain_ret0", retired, 32'd0);
    drive(4'd1, 4'd5, 4'd4, 4'd4, 32'h1, 32'h2);
    tick();
    chk("plain_ret1", retired, 32'd1);
    chk("coll_dstE", dstE, 4'hF);
    chk("coll_dstM", dstM, 4'd4);
    chk("coll_valM", valM, 32'h2);
    chk("coll_valE", valE, 32'h1);
    drive(4'd1, 4'd6, 4'd2, 4'hF, 32'h22, 32'h0);
    tick();
    chk("st_load", dstE, 4'd2);
    chk("st_ret2", retired, 32'd2);
    W_stall = 1'b1;
    drive(4'd1, 4'd6, 4'd7, 4'hF, 32'h77, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("st_hold_dstE", dstE, 4'd2);
      chk("st_hold_valE", valE, 32'h22);
      chk("st_hold_ret", retired, 32'd2);
    end
    W_stall = 1'b0;
    tick();
    chk("st_rel_dstE", dstE, 4'd7);
    chk("st_rel_ret", retired, 32'd3);
    W_bubble = 1'b1;
    tick();
    chk("bub_dstE", dstE, 4'hF);
    chk("bub_dstM", dstM, 4'hF);
    chk("bub_icode", W_icode, 4'd1);
    chk("bub_ret_dep", retired, 32'd4);
    tick();
    chk("bub_ret_same", retired, 32'd4);
    W_bubble = 1'b0;
    drive(4'd1, 4'd6, 4'd6, 4'hF, 32'h66, 32'h0);
    tick();
    chk("sb_load", dstE, 4'd6);
    W_stall = 1'b1;
    W_bubble = 1'b1;
    tick();
    chk("sb_hold_dstE", dstE, 4'd6);
    chk("sb_hold_ret", retired, 32'd4);
    W_stall = 1'b0;
    W_bubble = 1'b0;
    drive(4'd2, 4'd0, 4'hF, 4'hF, 32'h0, 32'h0);
    tick();
    chk("hlt_ret5", retired, 32'd5);
    chk("hlt_stat_now", Stat, 4'd2);
    chk("hlt_not_yet", halted, 1'b0);
    chk("hlt_dstE", dstE, 4'hF);
    drive(4'd1, 4'd6, 4'd1, 4'd2, 32'h11, 32'h12);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hlt_halted", halted, 1'b1);
      chk("hlt_stat", Stat, 4'd2);
      chk("hlt_ret_frozen", retired, 32'd5);
      chk("hlt_no_dstE", dstE, 4'hF);
      chk("hlt_no_dstM", dstM, 4'hF);
    end
    rst = 1'b1;
    tick();
    chk("rst2_stat", Stat, 4'd1);
    chk("rst2_halted", halted, 1'b0);
    chk("rst2_ret", retired, 32'd0);
    rst = 1'b0;
    drive(4'd3, 4'd5, 4'hF, 4'd2, 32'h0, 32'h9);
    tick();
    chk("adr_stat_now", Stat, 4'd3);
    chk("adr_no_dstM", dstM, 4'hF);
    drive(4'd1, 4'd6, 4'd5, 4'hF, 32'h55, 32'h0);
    tick();
    chk("adr_halted", halted, 1'b1);
    chk("adr_stat", Stat, 4'd3);
    chk("adr_ret", retired, 32'd0);
    rst = 1'b1;
    tick();
    chk("rst3_stat", Stat, 4'd1);
    chk("rst3_halted", halted, 1'b0);
    chk("rst3_ret", retired, 32'd0);
    chk("rst3_dstE", dstE, 4'hF);
    rst = 1'b0;
    tick();
    chk("resume_dstE", dstE, 4'd5);
    chk("resume_valE", valE, 32'h55);
    chk("resume_stat", Stat, 4'd1);
    drive(4'd1, 4'd1, 4'hF, 4'hF, 32'h0, 32'h0);
    tick();
    chk("resume_ret", retired, 32'd1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/writeback.md
# writeback

Y86 pipeline write-back stage: the W pipeline register and the driver side of the register-file write ports. Captures memory-stage results each cycle, drives dstE/dstM/valE/valM into the register file, and resolves same-register write collisions. Detects the first non-AOK instruction to reach W, freezes the machine and reports final status. Counts retired instructions.

## Interface
- WORD_W, 32, data width (matches `WORD)
- clk  in  1  pipeline clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- M_stat  in  4  status of instruction leaving M: AOK=1, HLT=2, ADR=3, INS=4
- M_icode  in  4  instruction code (HALT=0, NOP=1, ...)
- M_dstE  in  4  ALU-result destination; 4'hF (`RNONE) = none
- M_dstM  in  4  memory-result destination; 4'hF = none
- M_valE  in  32  ALU result
- m_valM  in  32  memory read data
- W_stall  in  1  hold W register
- W_bubble  in  1  load bubble into W register
- dstE  out  4  register-file E write index (4'hF = no write)
- dstM  out  4  register-file M write index
- valE  out  32  register-file E write data
- valM  out  32  register-file M write data
- W_icode  out  4  icode held in W (for forwarding and control)
- Stat  out  4  processor status
- halted  out  1  machine stopped
- retired  out  32  retired-instruction count

## Operation
- W register fields: valid, stat, icode, dstE, dstM, valE, valM.
- Register update priority per edge: rst > state STOP (hold) > W_stall (hold) > W_bubble (load bubble) > load M inputs.
- Bubble: valid=0, stat=AOK, icode=NOP, dstE=dstM=4'hF, valE=valM=0.
- Write-port drive (combinational from W register):
  - valid=0, or stat≠AOK, or state STOP: dstE=dstM=4'hF.
  - Otherwise dstE/dstM = held values; if held dstE==dstM≠4'hF, dstE forced to 4'hF (M write wins, e.g. popl %esp).
  - valE/valM always equal held values.
- State machine, two states:
  - RUN (reset state): valid=1 and stat≠AOK in W → STOP at next edge, latch stat into final-status register.
  - STOP: absorbing until rst; W register frozen; all inputs ignored; no writes driven.
- Stat: STOP → latched final status; RUN with valid and stat≠AOK → W stat; otherwise AOK.
- halted = (state==STOP), registered.
- retired: +1 on an edge where state RUN, valid=1, stat=AOK, W_stall=0. Wraps 32'hFFFFFFFF→0. A stalled instruction counts once, on the edge it departs. HLT instruction not counted.

## Timing
- Reset values: W register = bubble, state RUN, final status AOK, retired 0; outputs dstE=dstM=4'hF, valE=valM=0, W_icode=NOP, Stat=AOK, halted=0.
- Latency: M inputs sampled at edge N appear on write ports during cycle N→N+1; register file commits at edge N+1.
- Stall: outputs unchanged; same write re-driven each held cycle (idempotent).
- W_stall and W_bubble both high: stall wins.
- Exception: non-AOK instruction captured at edge N → Stat shows code in cycle N (combinational); its writes suppressed in cycle N; halted=1 from edge N+1.
- rst asserted in any state, including STOP or mid-stall: all state returns to reset values at that edge; capture resumes on the first edge after rst deasserts.

## Test plan
- Reset: hold rst 2 cycles with arbitrary M inputs → dstE=dstM=4'hF, Stat=1, halted=0, retired=0.
- Plain writes: M_stat=1, M_dstE=3, M_valE=32'h0000_00AA, M_dstM=4'hF → next cycle dstE=3, valE=32'hAA, dstM=4'hF; retired=1 after the following edge.
- Collision: M_dstE=4, M_dstM=4, M_valE=32'h1, m_valM=32'h2 → dstE=4'hF, dstM=4, valM=32'h2.
- Stall/bubble: load dstE=2, hold W_stall 3 cycles → dstE=2 all 3 cycles, retired +1 only after release; W_bubble → dstE=dstM=4'hF, retired unchanged; stall+bubble together → hold.
- Halt: M_stat=2, M_icode=0 after 5 AOK instructions → Stat=2 same cycle, halted=1 next cycle, retired=5 frozen, later M_stat=1 writes never driven.
- Reset from STOP: after ADR (Stat=3, halted=1) pulse rst 1 cycle → Stat=1, halted=0, retired=0; subsequent AOK instruction writes normally.
